fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq.sv | 146 ++++++++++++++
 tb/tb_fir_mac_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential FIR filter built around one signed multiply-accumulate
// unit that is time-shared over all taps.
//
// Each accepted sample shifts the history line. The block then spends TAPS
// cycles accumulating h[k]*x[k], and one more cycle rounding and saturating
// the sum into yOut.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   xIn       input sample (signed, DATA_W)
//   sample    sample strobe, accepted when ready=1
//   ready     block idle, a sample or coefficient write may be taken
//   coefWe    coefficient write strobe, honoured only while ready=1
//   coefAddr  coefficient index (AW bits); indices >= TAPS are ignored
//   coefData  coefficient value (signed, COEF_W, Q15 by default)
//   yOut      filter output, held until the next result
//   yValid    one-cycle pulse marking a new yOut
//   overrun   sticky flag: sample or coefficient write arrived while busy
module fir_mac_seq #(
  parameter  int DATA_W    = 16,
  parameter  int COEF_W    = 16,
  parameter  int TAPS      = 32,
  parameter  int ACC_W     = 40,
  parameter  int OUT_SHIFT = 15,
  localparam int AW        = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] xIn,
  input  logic                     sample,
  output logic                     ready,
  input  logic                     coefWe,
  input  logic        [AW-1:0]     coefAddr,
  input  logic signed [COEF_W-1:0] coefData,
  output logic signed [DATA_W-1:0] yOut,
  output logic                     yValid,
  output logic                     overrun
);

  // The tap counter must reach TAPS itself (the output cycle), hence one extra bit.
  localparam int KW = AW + 1;
  localparam int PW = DATA_W + COEF_W;

  localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {IDLE, MAC} state_t;

  state_t                     state;
  logic        [KW-1:0]       k;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DATA_W-1:0]   x_hist [TAPS];
  logic signed [COEF_W-1:0]   h_mem  [TAPS];

  logic        [AW-1:0]       k_idx;
  logic signed [PW-1:0]       x_ext;
  logic signed [PW-1:0]       h_ext;
  logic signed [PW-1:0]       prod;
  logic                       coef_addr_ok;

  // Round half up, arithmetic shift, then clamp to the DATA_W signed range.
  // One guard bit above ACC_W keeps the rounding add from wrapping.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = {a[ACC_W-1], a} + RND;
    t = t >>> OUT_SHIFT;
    if (t > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (t < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return t[DATA_W-1:0];
  endfunction

  // Single shared multiplier. During the output cycle k == TAPS, so the index
  // is parked at 0 to stay inside the arrays; that product is never used.
  always_comb begin
    k_idx = '0;
    if (k < KW'(TAPS))
      k_idx = k[AW-1:0];
    x_ext = PW'(x_hist[k_idx]);
    h_ext = PW'(h_mem[k_idx]);
    prod  = x_ext * h_ext;
  end

  assign coef_addr_ok = ({1'b0, coefAddr} < KW'(TAPS));

  // Stage boundary: history, coefficients, accumulator and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      k       <= '0;
      acc     <= '0;
      yOut    <= '0;
      yValid  <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_hist[i] <= '0;
        h_mem[i]  <= '0;
      end
    end else begin
      yValid <= 1'b0;

      // A write in the same edge as acceptance lands before the first MAC
      // edge reads h, so the new computation already uses it.
      if (coefWe) begin
        if (!ready)
          overrun <= 1'b1;
        else if (coef_addr_ok)
          h_mem[coefAddr] <= coefData;
      end

      case (state)
        IDLE: begin
          if (sample) begin
            for (int i = TAPS - 1; i > 0; i--)
              x_hist[i] <= x_hist[i-1];
            x_hist[0] <= xIn;
            acc       <= '0;
            k         <= '0;
            state     <= MAC;
            ready     <= 1'b0;
          end
        end
        MAC: begin
          if (sample)
            overrun <= 1'b1;
          if (k == KW'(TAPS)) begin
            yOut   <= round_sat(acc);
            yValid <= 1'b1;
            state  <= IDLE;
            ready  <= 1'b1;
          end else begin
            acc <= acc + ACC_W'(prod);
            k   <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: randomized self-checking bench for fir_mac_seq (default
// parameters). The reference model keeps the coefficient and sample history
// as plain integer arrays and computes each output as a direct sum of
// products, followed by rounding and saturation.
module tb_fir_mac_seq;

  localparam int NT = 32;

  logic               clk;
  logic               reset;
  logic signed [15:0] xIn;
  logic               sample;
  logic               ready;
  logic               coefWe;
  logic        [4:0]  coefAddr;
  logic signed [15:0] coefData;
  logic signed [15:0] yOut;
  logic               yValid;
  logic               overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int hm [NT];
  int xm [NT];

  fir_mac_seq dut (
    .clk      (clk),
    .reset    (reset),
    .xIn      (xIn),
    .sample   (sample),
    .ready    (ready),
    .coefWe   (coefWe),
    .coefAddr (coefAddr),
    .coefData (coefData),
    .yOut     (yOut),
    .yValid   (yValid),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_y();
    longint s;
    s = 0;
    for (int i = 0; i < NT; i++)
      s += longint'(hm[i]) * longint'(xm[i]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NT; i++) begin
      hm[i] = 0;
      xm[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    sample = 1'b0;
    coefWe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst ready",   ready,   1);
    check("rst yValid",  yValid,  0);
    check("rst yOut",    yOut,    0);
    check("rst overrun", overrun, 0);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic write_coef(input logic [4:0] a, input logic signed [15:0] d);
    coefWe   = 1'b1;
    coefAddr = a;
    coefData = d;
    hm[a]    = int'(d);
    @(negedge clk);
    coefWe = 1'b0;
  endtask

  // Called on a negedge with ready=1; returns on the negedge where yValid=1,
  // so a following call accepts back-to-back. With ov set, a stray sample at
  // MAC cycle 5 and a stray coefficient write at cycle 10 are injected.
  task automatic run_sample(input logic signed [15:0] x, input bit cw,
                            input logic [4:0] ca, input logic signed [15:0] cd,
                            input bit ov, input string tag);
    int cnt;
    bit rdy_bad;
    int exp_y;
    sample   = 1'b1;
    xIn      = x;
    coefWe   = cw;
    coefAddr = ca;
    coefData = cd;
    if (cw) hm[ca] = int'(cd);
    for (int i = NT - 1; i > 0; i--) xm[i] = xm[i-1];
    xm[0] = int'(x);
    exp_y = model_y();
    @(negedge clk);
    sample  = 1'b0;
    coefWe  = 1'b0;
    cnt     = 0;
    rdy_bad = 1'b0;
    while (!yValid && cnt < 100) begin
      if (ready !== 1'b0) rdy_bad = 1'b1;
      if (ov && cnt == 5) begin
        sample = 1'b1;
        xIn    = 16'($urandom);
      end else begin
        sample = 1'b0;
      end
      if (ov && cnt == 10) begin
        coefWe   = 1'b1;
        coefAddr = 5'($urandom);
        coefData = 16'($urandom);
      end else begin
        coefWe = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    sample = 1'b0;
    coefWe = 1'b0;
    check({tag, " latency"},   cnt,     33);
    check({tag, " ready_low"}, rdy_bad, 0);
    check({tag, " ready_out"}, ready,   1);
    check({tag, " yOut"},      yOut,    exp_y);
  endtask

  initial begin
    reset    = 1'b1;
    sample   = 1'b0;
    coefWe   = 1'b0;
    xIn      = '0;
    coefAddr = '0;
    coefData = '0;
    clear_model();

    // Basic single-tap result.
    do_reset();
    write_coef(5'd0, 16'sh4000);
    run_sample(16'sh2000, 1'b0, 5'd0, 16'sd0, 1'b0, "basic");
    check("basic const", yOut, 32'sh1000);

    // Rounding at the half-LSB boundary.
    do_reset();
    write_coef(5'd0, 16'sh0001);
    run_sample(16'sh4000, 1'b0, 5'd0, 16'sd0, 1'b0, "rnd_up");
    check("rnd_up const", yOut, 1);
    run_sample(16'sh3FFF, 1'b0, 5'd0, 16'sd0, 1'b0, "rnd_dn");
    check("rnd_dn const", yOut, 0);

    // Positive and negative saturation.
    do_reset();
    for (int i = 0; i < NT; i++) write_coef(5'(i), 16'sh7FFF);
    for (int i = 0; i < NT; i++) run_sample(16'sh7FFF, 1'b0, 5'd0, 16'sd0, 1'b0, "sat_pos");
    check("sat_pos const", yOut, 32767);
    for (int i = 0; i < NT; i++) write_coef(5'(i), 16'sh8000);
    run_sample(16'sh7FFF, 1'b0, 5'd0, 16'sd0, 1'b0, "sat_neg");
    check("sat_neg const", yOut, -32768);

    // Random coefficients and samples, some with a coefficient write on the
    // acceptance edge.
    do_reset();
    for (int i = 0; i < NT; i++)
      write_coef(5'(i), 16'(16'($urandom) >>> $urandom_range(0, 4)));
    for (int i = 0; i < 40; i++)
      run_sample(16'($urandom), 1'($urandom), 5'($urandom), 16'($urandom), 1'b0, "rand");
    check("overrun idle", overrun, 0);

    // Writes and samples while busy are dropped and latch overrun.
    run_sample(16'($urandom), 1'b0, 5'd0, 16'sd0, 1'b1, "ovr_run");
    check("overrun set", overrun, 1);
    run_sample(16'($urandom), 1'b0, 5'd0, 16'sd0, 1'b0, "ovr_next");
    run_sample(16'($urandom), 1'b0, 5'd0, 16'sd0, 1'b0, "ovr_next2");
    check("overrun sticky", overrun, 1);

    // Back-to-back impulse: h[k] = (k+1)*512, impulse of 64, so each output
    // after scaling by 2^-15 equals k+1.
    do_reset();
    for (int i = 0; i < NT; i++) write_coef(5'(i), 16'((i + 1) * 512));
    for (int i = 0; i < NT; i++) begin
      run_sample((i == 0) ? 16'sd64 : 16'sd0, 1'b0, 5'd0, 16'sd0, 1'b0, "impulse");
      check("impulse tap", yOut, i + 1);
    end

    // Abort by reset in the middle of a computation.
    run_sample(16'sh1234, 1'b0, 5'd0, 16'sd0, 1'b1, "pre_abort");
    sample = 1'b1;
    xIn    = 16'($urandom);
    @(negedge clk);
    sample = 1'b0;
    repeat (16) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort ready",   ready,   1);
    check("abort yValid",  yValid,  0);
    check("abort yOut",    yOut,    0);
    check("abort overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run_sample(16'($urandom), 1'b0, 5'd0, 16'sd0, 1'b0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
